// File: rtl/vmul_wb_queue_pkg.sv
// Shared constants and types for the vector-multiply writeback queue.
// Optional feature macro: VMUL_WB_QUEUE_BYPASS_EN (see vmul_wb_queue.sv).
package vmul_wb_queue_pkg;

  localparam int NUMLANES = 4;
  localparam int WIDTH    = 32;
  localparam int REGIDW   = 10;
  localparam int DEPTH    = 4;

  typedef struct packed {
    logic [REGIDW-1:0]         dst;
    logic [NUMLANES-1:0]       mask;
    logic [NUMLANES*WIDTH-1:0] data;
  } vwb_entry_t;

  // Occupancy counter needs one extra bit so full and empty are distinct.
  function automatic int vwb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vmul_wb_queue_mem.sv
// Writeback queue storage: register array, async read port and per-entry
// destination compare against a query id, qualified by a valid vector.
module vmul_wb_queue_mem #(
  parameter int DEPTH = 4,
  parameter int EW    = 142,
  parameter int DW    = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [EW-1:0]    wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [EW-1:0]    rdata_o,
  input  logic [DEPTH-1:0] vld_i,
  input  logic [DW-1:0]    qdst_i,
  output logic [DEPTH-1:0] hit_o
);

  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

  // Destination id occupies the top DW bits of each entry.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit_o[i] = vld_i[i] & (mem_q[i][EW-1 -: DW] == qdst_i);
  end

endmodule

// File: rtl/vmul_wb_queue.sv
// Writeback queue between the vector multiplier and the shared RF write port.
// Define VMUL_WB_QUEUE_BYPASS_EN for a zero-latency path when the queue is empty.
module vmul_wb_queue
  import vmul_wb_queue_pkg::*;
#(
  parameter int NUMLANES = vmul_wb_queue_pkg::NUMLANES,
  parameter int WIDTH    = vmul_wb_queue_pkg::WIDTH,
  parameter int REGIDW   = vmul_wb_queue_pkg::REGIDW,
  parameter int DEPTH    = vmul_wb_queue_pkg::DEPTH
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_we,
  input  logic [REGIDW-1:0]            in_dst,
  input  logic [NUMLANES-1:0]          in_mask,
  input  logic [NUMLANES*WIDTH-1:0]    in_result,
  input  logic                         flush,
  output logic                         stall_up,
  output logic                         wb_req,
  input  logic                         wb_grant,
  output logic [REGIDW-1:0]            wb_dst,
  output logic [NUMLANES-1:0]          wb_mask,
  output logic [NUMLANES*WIDTH-1:0]    wb_data,
  input  logic [REGIDW-1:0]            haz_dst,
  output logic                         haz_hit,
  output logic [vwb_cnt_w(DEPTH)-1:0]  count,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = vwb_cnt_w(DEPTH);
  localparam int EW = REGIDW + NUMLANES + NUMLANES*WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HIGHW_C = CW'(DEPTH - 1);

  typedef struct packed {
    logic [REGIDW-1:0]         dst;
    logic [NUMLANES-1:0]       mask;
    logic [NUMLANES*WIDTH-1:0] data;
  } entry_t;

  logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  entry_t           in_ent, head_ent, wb_ent;
  logic [EW-1:0]    rd_data;
  logic             in_vld, full, empty, q_pop, push, byp_take;
  logic [DEPTH-1:0] ent_vld, ent_hit;

  assign in_ent = '{dst: in_dst, mask: in_mask, data: in_result};
  assign in_vld = in_we & (|in_mask);
  assign full   = (cnt_q == DEPTH_C);
  assign empty  = (cnt_q == '0);
  assign q_pop  = ~empty & wb_grant;
  // A slot freed by a same-cycle pop lets a push into a full queue through.
  assign push   = in_vld & (~full | q_pop) & ~byp_take;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (in_vld & full & ~q_pop);
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (q_pop) rptr_d = rptr_q + 1'b1;
      if (push)  wptr_d = wptr_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(q_pop);
    end
  end

  // Entry i is live if it sits within count of the head; the head leaving
  // this cycle no longer counts as a pending hazard.
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [PW-1:0] off;
    assign off        = PW'(i) - rptr_q;
    assign ent_vld[i] = ({1'b0, off} < cnt_q) & ~(q_pop & (off == '0));
  end

  vmul_wb_queue_mem #(
    .DEPTH (DEPTH),
    .EW    (EW),
    .DW    (REGIDW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push & ~flush),
    .waddr_i (wptr_q),
    .wdata_i (in_ent),
    .raddr_i (rptr_q),
    .rdata_o (rd_data),
    .vld_i   (ent_vld),
    .qdst_i  (haz_dst),
    .hit_o   (ent_hit)
  );

  assign head_ent = rd_data;

`ifdef VMUL_WB_QUEUE_BYPASS_EN
  logic byp;
  assign byp      = empty & in_vld;
  assign byp_take = byp & wb_grant;
  assign wb_req   = ~empty | byp;
  assign wb_ent   = byp ? in_ent : head_ent;
  assign haz_hit  = (|ent_hit) | (byp & (in_dst == haz_dst));
`else
  assign byp_take = 1'b0;
  assign wb_req   = ~empty;
  assign wb_ent   = head_ent;
  assign haz_hit  = |ent_hit;
`endif

  assign wb_dst   = wb_ent.dst;
  assign wb_mask  = wb_ent.mask;
  assign wb_data  = wb_ent.data;
  assign stall_up = (cnt_q >= HIGHW_C);
  assign count    = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_vmul_wb_queue.sv
// Scoreboard bench for vmul_wb_queue: queue-based reference model, directed
// scenarios then randomized traffic; a monitor checks every granted writeback.
module tb_vmul_wb_queue;
  import vmul_wb_queue_pkg::*;

`ifdef VMUL_WB_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_we = 1'b0;
  logic [9:0]    in_dst = '0;
  logic [3:0]    in_mask = '0;
  logic [127:0]  in_result = '0;
  logic          flush = 1'b0;
  logic          stall_up, wb_req, haz_hit, overflow;
  logic          wb_grant = 1'b0;
  logic [9:0]    wb_dst;
  logic [3:0]    wb_mask;
  logic [127:0]  wb_data;
  logic [9:0]    haz_dst = '0;
  logic [2:0]    count;

  vmul_wb_queue dut (
    .clk(clk), .resetn(resetn), .in_we(in_we), .in_dst(in_dst),
    .in_mask(in_mask), .in_result(in_result), .flush(flush),
    .stall_up(stall_up), .wb_req(wb_req), .wb_grant(wb_grant),
    .wb_dst(wb_dst), .wb_mask(wb_mask), .wb_data(wb_data),
    .haz_dst(haz_dst), .haz_hit(haz_hit), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  vwb_entry_t mq[$];   // entries the queue holds
  vwb_entry_t sb[$];   // accepted writebacks not yet seen on the RF port
  bit m_ovf = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: every granted writeback must be the oldest outstanding one.
  always @(negedge clk) begin
    if (resetn && wb_req && wb_grant) begin
      if (sb.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        chk("wb_dst", wb_dst, sb[0].dst);
        chk("wb_mask", wb_mask, sb[0].mask);
        chk("wb_data", wb_data, sb[0].data);
        void'(sb.pop_front());
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0; in_we = 1'b0; wb_grant = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    mq.delete(); sb.delete(); m_ovf = 1'b0;
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic cycle(input bit we, input logic [9:0] dst, input logic [3:0] mask,
                       input logic [127:0] data, input bit gr, input bit fl,
                       input logic [9:0] hz);
    vwb_entry_t e;
    bit vin, byp, qpop, stor, ehaz;
    int n;
    in_we = we; in_dst = dst; in_mask = mask; in_result = data;
    wb_grant = gr; flush = fl; haz_dst = hz;
    e = '{dst: dst, mask: mask, data: data};
    n = mq.size();
    vin  = we && (mask != 0);
    byp  = BYP && (n == 0) && vin;
    qpop = (n > 0) && gr;
    stor = vin && !(byp && gr) && ((n < DEPTH) || qpop);
    ehaz = byp && (dst == hz);
    foreach (mq[i]) if (!(qpop && i == 0) && mq[i].dst == hz) ehaz = 1'b1;
    if ((byp && gr) || (stor && !fl)) sb.push_back(e);
    @(negedge clk);
    chk("wb_req", wb_req, (n > 0) || byp);
    chk("count", count, n);
    chk("stall_up", stall_up, n >= DEPTH - 1);
    chk("overflow", overflow, m_ovf);
    chk("haz_hit", haz_hit, ehaz);
    @(posedge clk);
    if (vin && n == DEPTH && !qpop) m_ovf = 1'b1;
    if (fl) begin
      mq.delete(); sb.delete();
    end else begin
      if (qpop) void'(mq.pop_front());
      if (stor) mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input bit gr, input logic [9:0] hz);
    cycle(1'b0, 10'd0, 4'd0, 128'd0, gr, 1'b0, hz);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    do_reset();
    idle(1'b0, 10'd5);

    // Single writeback, then drain it.
    cycle(1'b1, 10'h05, 4'b1111, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 1'b0, 10'h05);
    idle(1'b1, 10'h05);
    idle(1'b0, 10'h05);

    // Fill, overflow attempt, head intact, drain in order.
    for (int i = 0; i < 5; i++) cycle(1'b1, 10'(i + 1), 4'b0101, rnd128(), 1'b0, 1'b0, 10'd1);
    idle(1'b0, 10'd1);
    for (int i = 0; i < 5; i++) idle(1'b1, 10'd2);

    // Full queue: push and grant together.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 10'(i + 8), 4'b1000, rnd128(), 1'b0, 1'b0, 10'd0);
    cycle(1'b1, 10'd20, 4'b0011, rnd128(), 1'b1, 1'b0, 10'd20);
    for (int i = 0; i < 5; i++) idle(1'b1, 10'd20);

    // Zero mask is discarded.
    cycle(1'b1, 10'd9, 4'b0000, rnd128(), 1'b0, 1'b0, 10'd9);
    idle(1'b0, 10'd9);

    // Hazard lookup.
    cycle(1'b1, 10'd3, 4'b0001, rnd128(), 1'b0, 1'b0, 10'd7);
    cycle(1'b1, 10'd7, 4'b0010, rnd128(), 1'b0, 1'b0, 10'd7);
    idle(1'b0, 10'd7);
    idle(1'b1, 10'd7);
    idle(1'b1, 10'd7);
    idle(1'b0, 10'd7);

    // Flush with three entries.
    for (int i = 0; i < 3; i++) cycle(1'b1, 10'(i), 4'b1111, rnd128(), 1'b0, 1'b0, 10'd1);
    cycle(1'b0, 10'd0, 4'd0, 128'd0, 1'b0, 1'b1, 10'd1);
    idle(1'b0, 10'd1);

    // Empty queue, push with grant in the same cycle.
    cycle(1'b1, 10'h2A, 4'b0110, rnd128(), 1'b1, 1'b0, 10'h2A);
    idle(1'b1, 10'h2A);
    idle(1'b0, 10'h2A);

    // Randomized traffic with a reset in the middle.
    for (int k = 0; k < 600; k++) begin
      logic [3:0] m;
      if (k == 300) do_reset();
      m = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom);
      cycle($urandom_range(0, 3) != 0, 10'($urandom_range(0, 7)), m, rnd128(),
            $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
            10'($urandom_range(0, 7)));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1, 10'd0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
